// File: rtl/fpu_add_pipe_if.sv
// AXI-stream bundle for the binary32 adder: two operand channels joined into
// one transfer, plus the result channel with its sideband tag and flags.
interface fpu_add_pipe_if #(
   parameter int TUSER_W = 4
);
   logic [31:0]        s_axis_a_tdata;
   logic [TUSER_W-1:0] s_axis_a_tuser;
   logic               s_axis_a_tvalid;
   logic               s_axis_a_tready;
   logic [31:0]        s_axis_b_tdata;
   logic               s_axis_b_tsub;
   logic               s_axis_b_tvalid;
   logic               s_axis_b_tready;
   logic [31:0]        m_axis_result_tdata;
   logic [TUSER_W-1:0] m_axis_result_tuser;
   logic [3:0]         m_axis_result_tflags;
   logic               m_axis_result_tvalid;
   logic               m_axis_result_tready;

   // Adder side: consumes operands, produces results.
   modport slave (
      input  s_axis_a_tdata, s_axis_a_tuser, s_axis_a_tvalid,
      input  s_axis_b_tdata, s_axis_b_tsub, s_axis_b_tvalid,
      output s_axis_a_tready, s_axis_b_tready,
      output m_axis_result_tdata, m_axis_result_tuser, m_axis_result_tflags,
      output m_axis_result_tvalid,
      input  m_axis_result_tready
   );

   // Environment side: produces operands, consumes results.
   modport master (
      output s_axis_a_tdata, s_axis_a_tuser, s_axis_a_tvalid,
      output s_axis_b_tdata, s_axis_b_tsub, s_axis_b_tvalid,
      input  s_axis_a_tready, s_axis_b_tready,
      input  m_axis_result_tdata, m_axis_result_tuser, m_axis_result_tflags,
      input  m_axis_result_tvalid,
      output m_axis_result_tready
   );
endinterface

// File: rtl/fpu_add_pipe.sv
// Pipelined binary32 adder/subtractor with joined AXI-stream operand inputs,
// round-to-nearest-even, denormal flushing, exception flags and a stallable
// LATENCY-deep result pipeline whose bubbles collapse under backpressure.
module fpu_add_pipe #(
   parameter int LATENCY = 3,
   parameter int TUSER_W = 4
) (
   input  logic          aclk,
   input  logic          areset,
   fpu_add_pipe_if.slave axis
);

   typedef struct packed {
      logic [31:0] data;
      logic [3:0]  flags;   // {invalid, overflow, underflow, inexact}
   } res_t;

   // Leading-zero count of a 27-bit value (27 when the value is zero).
   function automatic logic [4:0] clz27(input logic [26:0] v);
      logic [4:0] c;
      logic       found;
      c     = '0;
      found = 1'b0;
      for (int i = 26; i >= 0; i--) begin
         if (!found) begin
            if (v[i]) found = 1'b1;
            else      c = c + 5'd1;
         end
      end
      return c;
   endfunction

   // Full binary32 add: finite path computed unconditionally, specials
   // selected at the end. Mantissas carry guard/round/sticky (27 bits).
   function automatic res_t fp_add(input logic [31:0] a, input logic [31:0] b,
                                   input logic sub);
      res_t               r;
      logic               sa, sb, sx, sy, swap;
      logic [7:0]         ea, eb, ex, ey, d;
      logic [22:0]        ma, mb;
      logic               a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_zero, b_zero;
      logic [23:0]        mx, my;
      logic [26:0]        xal, yal, n;
      logic [53:0]        yw;
      logic [27:0]        s;
      logic [4:0]         lz;
      logic signed [9:0]  e;
      logic [23:0]        m24;
      logic [24:0]        mr;
      logic               g, st, rup, inexact;

      r.data  = '0;
      r.flags = '0;
      yw      = '0;

      sa = a[31];
      ea = a[30:23];
      ma = a[22:0];
      sb = b[31] ^ sub;
      eb = b[30:23];
      mb = b[22:0];

      a_nan  = (ea == 8'hFF) && (ma != '0);
      b_nan  = (eb == 8'hFF) && (mb != '0);
      a_snan = a_nan && !ma[22];
      b_snan = b_nan && !mb[22];
      a_inf  = (ea == 8'hFF) && (ma == '0);
      b_inf  = (eb == 8'hFF) && (mb == '0);
      // Exponent 0 covers both true zeros and flushed denormals.
      a_zero = (ea == 8'h00);
      b_zero = (eb == 8'h00);

      // Order operands by magnitude so the subtraction never goes negative.
      swap = {eb, mb} > {ea, ma};
      sx   = swap ? sb : sa;
      sy   = swap ? sa : sb;
      ex   = swap ? eb : ea;
      ey   = swap ? ea : eb;
      mx   = {1'b1, swap ? mb : ma};
      my   = {1'b1, swap ? ma : mb};
      d    = ex - ey;

      // Align the smaller operand; everything shifted past the round bit
      // collapses into the sticky bit.
      xal = {mx, 3'b000};
      if (d >= 8'd27) begin
         yal = 27'd1;
      end else begin
         yw  = {my, 3'b000, 27'd0} >> d;
         yal = {yw[53:28], yw[27] | (|yw[26:0])};
      end

      if (sx == sy) s = {1'b0, xal} + {1'b0, yal};
      else          s = {1'b0, xal} - {1'b0, yal};

      // Normalise: one-bit right shift on carry-out, otherwise left by lz.
      lz = clz27(s[26:0]);
      if (s[27]) begin
         n = {s[27:2], s[1] | s[0]};
         e = $signed({2'b00, ex}) + 10'sd1;
      end else begin
         n = s[26:0] << lz;
         e = $signed({2'b00, ex}) - $signed({5'd0, lz});
      end

      // Round to nearest, ties to even.
      m24     = n[26:3];
      g       = n[2];
      st      = n[1] | n[0];
      inexact = g | st;
      rup     = g & (st | m24[0]);
      mr      = {1'b0, m24} + {24'd0, rup};
      if (mr[24]) begin
         mr = mr >> 1;
         e  = e + 10'sd1;
      end

      if (a_nan || b_nan) begin
         r.data  = 32'h7FC0_0000;
         r.flags = {a_snan | b_snan, 3'b000};
      end else if (a_inf && b_inf && (sa != sb)) begin
         r.data  = 32'h7FC0_0000;
         r.flags = 4'b1000;
      end else if (a_inf) begin
         r.data = {sa, 8'hFF, 23'd0};
      end else if (b_inf) begin
         r.data = {sb, 8'hFF, 23'd0};
      end else if (a_zero && b_zero) begin
         // Only two negative zeros keep the sign.
         r.data = {sa & sb, 31'd0};
      end else if (a_zero) begin
         r.data = {sb, eb, mb};
      end else if (b_zero) begin
         r.data = {sa, ea, ma};
      end else if (s == '0) begin
         // Exact cancellation always yields +0.
         r.data = 32'h0000_0000;
      end else if (e > 10'sd254) begin
         r.data  = {sx, 8'hFF, 23'd0};
         r.flags = 4'b0101;
      end else if (e < 10'sd1) begin
         r.data  = {sx, 31'd0};
         r.flags = 4'b0011;
      end else begin
         r.data  = {sx, e[7:0], mr[22:0]};
         r.flags = {3'b000, inexact};
      end
      return r;
   endfunction

   logic [LATENCY-1:0] vld_p;
   logic [LATENCY-1:0] go;
   logic [31:0]        data_p [LATENCY];
   logic [TUSER_W-1:0] user_p [LATENCY];
   logic [3:0]         flag_p [LATENCY];
   res_t               res_in;
   logic               accept;

   // A stage can load when some stage at or beyond it is empty, or the
   // consumer is taking the last stage this cycle.
   for (genvar gi = 0; gi < LATENCY; gi++) begin : g_go
      assign go[gi] = axis.m_axis_result_tready | ~(&vld_p[LATENCY-1:gi]);
   end

   assign accept = axis.s_axis_a_tvalid & axis.s_axis_b_tvalid & go[0] & ~areset;
   assign axis.s_axis_a_tready = accept;
   assign axis.s_axis_b_tready = accept;

   assign res_in = fp_add(axis.s_axis_a_tdata, axis.s_axis_b_tdata, axis.s_axis_b_tsub);

   // Output data is masked by the last valid bit so it reads zero when idle
   // or in reset without resetting the data registers.
   assign axis.m_axis_result_tvalid = vld_p[LATENCY-1];
   assign axis.m_axis_result_tdata  = vld_p[LATENCY-1] ? data_p[LATENCY-1] : '0;
   assign axis.m_axis_result_tuser  = vld_p[LATENCY-1] ? user_p[LATENCY-1] : '0;
   assign axis.m_axis_result_tflags = vld_p[LATENCY-1] ? flag_p[LATENCY-1] : '0;

   // Stage valid bits: shift forward wherever the downstream slot frees up.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         vld_p <= '0;
      end else begin
         if (go[0]) vld_p[0] <= accept;
         for (int i = 1; i < LATENCY; i++) begin
            if (go[i]) vld_p[i] <= vld_p[i-1];
         end
      end
   end

   // Stage payloads move in lockstep with their valid bits.
   always_ff @(posedge aclk) begin
      if (go[0]) begin
         data_p[0] <= res_in.data;
         user_p[0] <= axis.s_axis_a_tuser;
         flag_p[0] <= res_in.flags;
      end
      for (int i = 1; i < LATENCY; i++) begin
         if (go[i]) begin
            data_p[i] <= data_p[i-1];
            user_p[i] <= user_p[i-1];
            flag_p[i] <= flag_p[i-1];
         end
      end
   end

endmodule

// File: doc/fpu_add_pipe.md
Name: fpu_add_pipe

Overview:
- Synthesizable, parametrised single-precision floating-point adder/subtractor.
- Next generation of the FPU add block. Adds configurable pipeline latency, a subtract mode, sideband passthrough, exception flags, and full AXI-stream ready/valid backpressure.
- Sits between AXI-stream operand producers and result consumers in the accelerator datapath. Replaces the non-synthesizable simulation adder in both simulation and FPGA builds.

Parameters:
- LATENCY, 3, cycles from accepted operand pair to m_axis_result_tvalid with no backpressure; legal range 1..8.
- TUSER_W, 4, width of sideband tag carried from operand A to the result unchanged.

Ports:
- aclk  in  1  clock, all logic on rising edge
- areset  in  1  asynchronous active-high reset
- s_axis_a_tdata  in  32  operand A, IEEE-754 binary32
- s_axis_a_tuser  in  TUSER_W  sideband tag
- s_axis_a_tvalid  in  1  A valid
- s_axis_a_tready  out  1  A accepted
- s_axis_b_tdata  in  32  operand B, binary32
- s_axis_b_tsub  in  1  1 = compute A−B, 0 = A+B
- s_axis_b_tvalid  in  1  B valid
- s_axis_b_tready  out  1  B accepted
- m_axis_result_tdata  out  32  result
- m_axis_result_tuser  out  TUSER_W  tag of the originating A beat
- m_axis_result_tflags  out  4  {invalid, overflow, underflow, inexact}
- m_axis_result_tvalid  out  1  result valid
- m_axis_result_tready  in  1  consumer ready

Behaviour:
- Reset:
  - On areset high, all stage valid bits clear immediately.
  - m_axis_result_tvalid=0; m_axis_result_tdata, m_axis_result_tuser and m_axis_result_tflags read 0.
  - Both treadys read 0 while reset is asserted.
  - In-flight data is discarded; no partial result appears after release.
- Join handshake:
  - An operand pair is accepted on a cycle when a_tvalid & b_tvalid & stage0_free.
  - a_tready = b_tready = a_tvalid & b_tvalid & stage0_free. Both channels always transfer together; one-sided valid never transfers.
  - stage0_free = stage0 empty OR stage0 advancing.
- Pipeline:
  - LATENCY register stages, each holding {valid, data, tuser, flags}. Arithmetic may be retimed across stages freely.
  - Stage i advances when stage i+1 is empty or advancing. The last stage advances when m_axis_result_tready=1.
  - Bubbles collapse under stall; capacity is LATENCY beats.
  - Throughput is 1 result/cycle with m_axis_result_tready held high. Order is strictly FIFO.
  - Output holds tdata/tuser/tflags stable while tvalid=1 and tready=0.
- Arithmetic, binary32:
  - Effective B sign = b_sign XOR s_axis_b_tsub.
  - Round-to-nearest-even, with guard/round/sticky bits across the full alignment shift.
  - Denormal inputs are flushed to signed zero before the add and raise no flag.
  - Tiny results (exponent < 1 after rounding) are flushed to signed zero; set underflow and inexact.
  - Overflow produces ±inf; set overflow and inexact.
  - Any NaN input gives canonical 0x7FC00000; invalid is set only for signalling NaN inputs (mantissa MSB=0).
  - inf + (−inf) gives 0x7FC00000 with invalid set. inf ± finite gives that inf.
  - Exact cancellation x + (−x) gives +0x00000000. (−0) + (−0) gives 0x80000000. (+0) + (−0) gives +0.
  - inexact is set when any discarded bits are nonzero.
- Simultaneous events: accept and output drain in the same cycle with a full pipe must not lose or duplicate a beat.

Test Plan:
- A=0x3F800000, B=0x40000000, sub=0, tuser=0x5, tready=1 → after exactly LATENCY cycles: tdata=0x40400000, tuser=0x5, flags=0000.
- A=0x3F800000, B=0x3F800000, sub=1 → 0x00000000, flags=0000. A=0x80000000, B=0x00000000, sub=1 → 0x80000000.
- A=0x3F800000, B=0x33800000 (tie) → 0x3F800000, flags=0001. A=0x7F7FFFFF, B=0x7F7FFFFF → 0x7F800000, flags=0101.
- A=0x7F800000, B=0xFF800000 → 0x7FC00000, flags=1000. A=0x7F800001 (sNaN), B=0x3F800000 → 0x7FC00000, flags=1000.
- Backpressure: stream 10 pairs back-to-back, tags 0..9, A=i, B=0; hold tready=0 for cycles 4..12.
  - Treadys drop once LATENCY beats are buffered.
  - All 10 results emerge in order with no loss or duplicates.
  - Output stays stable during the stall.
- Reset mid-operation:
  - Assert areset asynchronously with 3 beats in flight.
  - tvalid drops in the same cycle, before the next clock edge.
  - After release and 2·LATENCY idle cycles, no result is emitted. A new pair then completes in LATENCY cycles.
